reg_file_gen: RTL and testbench

Parametrised successor to the processor's fixed 16x16 register file. It provides NUM_RD registered read ports and one muxed write port. The destination-address and data-source selection happen inside the block. A per-register pending-write scoreboard lets the decode stage see registers awaiting a load or ALU writeback. The block sits between decode (read/reserve) and writeback (write) in the 16-bit datapath.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 24 ++
 rtl/reg_file_gen.sv | 77 +++++++
 tb/tb_reg_file_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, r0 address constant and write-request type for the register file
package regfile_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits; a reserve beats a same-edge clear, r0 never pending
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);
  logic [2**ADDR_W-1:0] nxt;
  // next pending state: set wins over clear, bit 0 forced low
  always_comb begin
    nxt = '0;
    for (int i = 1; i < 2**ADDR_W; i++)
      nxt[i] = (set_en && set_addr == ADDR_W'(i)) || (busy_vec[i] && !(clr_en && clr_addr == ADDR_W'(i)));
  end
  // scoreboard register
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_vec <= '0;
    else busy_vec <= nxt;
endmodule

// File: rtl/reg_file_gen.sv
// reg_file_gen: parametrised register file with NUM_RD registered read ports, one muxed write port and a pending-write scoreboard; define REGFILE_BYPASS_EN for write-to-read bypass
module reg_file_gen import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic                     wr_dst_sel,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic                     wr_mem_sel,
  input  logic [DATA_W-1:0]        wr_data_alu,
  input  logic [DATA_W-1:0]        wr_data_mem,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic [15:0]              wr_count
);
  localparam int DEPTH = 2**ADDR_W;
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t w;
  logic w_ok;
  logic [DATA_W-1:0] mem [DEPTH];
  // destination and source selection for the single write port
  always_comb w = '{en: wr_en, addr: wr_dst_sel ? wr_addr_a : wr_addr_b, data: wr_mem_sel ? wr_data_mem : wr_data_alu};
  assign w_ok = w.en && w.addr != ADDR_W'(REG_ZERO);
  // storage and commit counter; r0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_count <= '0;
    end else if (w_ok) begin
      mem[w.addr] <= w.data;
      wr_count <= wr_count + 16'd1;
    end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (w_ok),
    .clr_addr (w.addr),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .busy_vec (busy_vec)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] q;
    logic              b;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign hit = w_ok && w.addr == ra;
`else
    assign hit = 1'b0;
`endif
    // read port register; a bypass hit takes the incoming write and post-edge busy state
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        q <= '0;
        b <= 1'b0;
      end else begin
        q <= hit ? w.data : mem[ra];
        b <= hit ? (rsv_en && rsv_addr == ra) : busy_vec[ra];
      end
    assign rd_data[k*DATA_W +: DATA_W] = q;
    assign rd_busy[k] = b;
  end
endmodule

// File: tb/tb_reg_file_gen.sv
// tb_reg_file_gen: directed and random checks of reg_file_gen against an array-based reference model
module tb_reg_file_gen;
  localparam int DW = 16, AW = 4, NR = 5, D = 16;
  logic clk = 0, rst = 0;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_busy;
  logic wr_en, wr_dst_sel, wr_mem_sel, rsv_en;
  logic [AW-1:0] wr_addr_a, wr_addr_b, rsv_addr;
  logic [DW-1:0] wr_data_alu, wr_data_mem;
  logic [D-1:0] busy_vec;
  logic [15:0] wr_count;
  reg_file_gen #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_dst_sel(wr_dst_sel), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_mem_sel(wr_mem_sel), .wr_data_alu(wr_data_alu), .wr_data_mem(wr_data_mem),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] m_mem [D];
  logic m_busy [D];
  logic [15:0] m_cnt;
  int passed = 0, total = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = '0;
  endtask
  task automatic idle();
    rd_addr = '0; wr_en = 0; wr_dst_sel = 0; wr_mem_sel = 0; rsv_en = 0;
    wr_addr_a = '0; wr_addr_b = '0; rsv_addr = '0; wr_data_alu = '0; wr_data_mem = '0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data == '0), 32'd1);
    check({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
    check({tag, "_busy_vec"}, 32'(busy_vec), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
  endtask
  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_dst_sel = 1; wr_addr_a = a; wr_mem_sel = 0; wr_data_alu = d;
  endtask
  // predicts one edge from the current inputs, advances the model, then compares every output
  task automatic cyc();
    logic [DW-1:0] ed [NR];
    logic eb [NR];
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [D-1:0] bv;
    wa = wr_dst_sel ? wr_addr_a : wr_addr_b;
    wd = wr_mem_sel ? wr_data_mem : wr_data_alu;
    for (int k = 0; k < NR; k++) begin
      ra = rd_addr[k*AW +: AW];
      ed[k] = m_mem[ra];
      eb[k] = m_busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wa != 0 && ra == wa) begin
        ed[k] = wd;
        eb[k] = rsv_en && rsv_addr == wa;
      end
`endif
    end
    if (wr_en && wa != 0) begin
      m_mem[wa] = wd;
      m_busy[wa] = 1'b0;
      m_cnt = m_cnt + 16'd1;
    end
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rd_data%0d", k), 32'(rd_data[k*DW +: DW]), 32'(ed[k]));
      check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(eb[k]));
    end
    for (int i = 0; i < D; i++) bv[i] = m_busy[i];
    check("busy_vec", 32'(busy_vec), 32'(bv));
    check("wr_count", 32'(wr_count), 32'(m_cnt));
  endtask
  initial begin
    idle();
    model_reset();
    #1 rst = 1;
    #2 check_zero("por");
    @(posedge clk);
    #1 rst = 0;
    write(3, 16'hBEEF); cyc();
    idle(); rd_addr[AW-1:0] = 3; cyc();
    check("beef", 32'(rd_data[DW-1:0]), 32'h0000BEEF);
    check("cnt1", 32'(wr_count), 32'd1);
    wr_en = 1; wr_dst_sel = 0; wr_addr_b = 7; wr_addr_a = 3; wr_mem_sel = 1;
    wr_data_mem = 16'h1234; wr_data_alu = 16'hFFFF; cyc();
    idle(); rd_addr[AW-1:0] = 7; rd_addr[AW +: AW] = 3; cyc();
    check("mux_r7", 32'(rd_data[DW-1:0]), 32'h00001234);
    check("mux_r3", 32'(rd_data[DW +: DW]), 32'h0000BEEF);
    write(0, 16'hAAAA); rsv_en = 1; rsv_addr = 0; cyc();
    idle(); cyc();
    check("r0_data", 32'(rd_data[DW-1:0]), 32'd0);
    check("r0_busy", 32'(busy_vec[0]), 32'd0);
    check("r0_cnt", 32'(wr_count), 32'd2);
    idle(); rsv_en = 1; rsv_addr = 5; cyc();
    check("rsv5", 32'(busy_vec[5]), 32'd1);
    idle(); write(5, 16'h5555); cyc();
    check("clr5", 32'(busy_vec[5]), 32'd0);
    write(5, 16'h6666); rsv_en = 1; rsv_addr = 5; cyc();
    check("wr_rsv5", 32'(busy_vec[5]), 32'd1);
    idle(); rd_addr[AW-1:0] = 5; cyc();
    check("r5_data", 32'(rd_data[DW-1:0]), 32'h00006666);
    check("r5_busy", 32'(rd_busy[0]), 32'd1);
    idle(); write(9, 16'h0011); cyc();
    write(9, 16'h0022); rd_addr = {NR{4'd9}}; cyc();
    for (int k = 0; k < NR; k++)
`ifdef REGFILE_BYPASS_EN
      check($sformatf("raw9_%0d", k), 32'(rd_data[k*DW +: DW]), 32'h00000022);
`else
      check($sformatf("raw9_%0d", k), 32'(rd_data[k*DW +: DW]), 32'h00000011);
`endif
    write(2, 16'h0042); cyc();
    #2 rst = 1;
    #1 check_zero("mid_rst");
    model_reset();
    @(negedge clk) rst = 0;
    idle(); rd_addr[AW-1:0] = 2; cyc();
    for (int n = 0; n < 600; n++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_dst_sel = 1'($urandom_range(0, 1));
      wr_mem_sel = 1'($urandom_range(0, 1));
      rsv_en = 1'($urandom_range(0, 1));
      wr_addr_a = AW'($urandom());
      wr_addr_b = AW'($urandom());
      rsv_addr = AW'($urandom());
      wr_data_alu = DW'($urandom());
      wr_data_mem = DW'($urandom());
      rd_addr = (NR*AW)'($urandom());
      if (n % 7 == 0) rd_addr[AW-1:0] = wr_dst_sel ? wr_addr_a : wr_addr_b;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
